// File: rtl/rtc_hms_counter_if.sv
// Bus bundle for rtc_hms_counter: control/load/alarm inputs and time/glyph/pulse outputs.
interface rtc_hms_counter_if #(
  parameter int GLYPH_W = 6
);
  logic                   run_en;
  logic                   load_valid;
  logic [23:0]            load_time;
  logic                   alarm_en;
  logic [23:0]            alarm_time;
  logic [23:0]            time_bcd;
  logic [6*GLYPH_W-1:0]   disp_time;
  logic                   sec_pulse;
  logic                   load_err;
  logic                   alarm_hit;

  // Controller side: drives requests, observes time and pulses.
  modport master (
    output run_en, load_valid, load_time, alarm_en, alarm_time,
    input  time_bcd, disp_time, sec_pulse, load_err, alarm_hit
  );

  // Counter side.
  modport slave (
    input  run_en, load_valid, load_time, alarm_en, alarm_time,
    output time_bcd, disp_time, sec_pulse, load_err, alarm_hit
  );
endinterface

// File: rtl/rtc_hms_counter.sv
// HH:MM:SS BCD real-time counter with 1 Hz prescaler, 12/24h mode,
// validated load, one-shot alarm and per-digit glyph codes.
module rtc_hms_counter #(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int GLYPH_BASE    = 26,
  parameter int GLYPH_W       = 6,
  parameter int MODE_24H      = 1
) (
  input logic               clk,
  input logic               rst_n,
  rtc_hms_counter_if.slave  bus
);

  localparam int              CW       = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0]   TERM     = CW'(TICKS_PER_SEC - 1);
  localparam logic [23:0]     RST_TIME = (MODE_24H != 0) ? 24'h000000 : 24'h120000;

  logic [CW-1:0] cnt;
  logic [23:0]   tm;
  logic [23:0]   nxt;
  logic          tick;
  logic          load_ok;
  logic          alarm_ok;
  logic          sec_pulse_q, load_err_q, alarm_hit_q;

  // A BCD HHMMSS word is legal when every digit is decimal, tens of
  // minutes/seconds are 0..5, and the hour is in range for the mode.
  function automatic logic time_ok(input logic [23:0] t);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 6; i++)
      if (t[i*4 +: 4] > 4'd9) ok = 1'b0;
    if (t[7:4] > 4'd5 || t[15:12] > 4'd5) ok = 1'b0;
    // With decimal digits, a raw compare of the BCD byte orders hours numerically.
    if (MODE_24H != 0) begin
      if (t[23:16] > 8'h23) ok = 1'b0;
    end else begin
      if (t[23:16] == 8'h00 || t[23:16] > 8'h12) ok = 1'b0;
    end
    return ok;
  endfunction

  // Hour advance: 23->00 in 24h, 12->01 in 12h, otherwise plain BCD +1.
  function automatic logic [7:0] hour_inc(input logic [7:0] h);
    logic [7:0] r;
    if (MODE_24H != 0 && h == 8'h23)      r = 8'h00;
    else if (MODE_24H == 0 && h == 8'h12) r = 8'h01;
    else if (h[3:0] == 4'd9)              r = {h[7:4] + 4'd1, 4'd0};
    else                                  r = {h[7:4], h[3:0] + 4'd1};
    return r;
  endfunction

  // Full one-second advance with every carry resolved in one cycle.
  function automatic logic [23:0] time_inc(input logic [23:0] t);
    logic [23:0] n;
    n = t;
    if (t[3:0] != 4'd9) n[3:0] = t[3:0] + 4'd1;
    else begin
      n[3:0] = 4'd0;
      if (t[7:4] != 4'd5) n[7:4] = t[7:4] + 4'd1;
      else begin
        n[7:4] = 4'd0;
        if (t[11:8] != 4'd9) n[11:8] = t[11:8] + 4'd1;
        else begin
          n[11:8] = 4'd0;
          if (t[15:12] != 4'd5) n[15:12] = t[15:12] + 4'd1;
          else begin
            n[15:12] = 4'd0;
            n[23:16] = hour_inc(t[23:16]);
          end
        end
      end
    end
    return n;
  endfunction

  assign tick     = bus.run_en && (cnt == TERM);
  assign nxt      = time_inc(tm);
  assign load_ok  = time_ok(bus.load_time);
  assign alarm_ok = time_ok(bus.alarm_time);

  // Prescaler, time registers and registered one-cycle pulses.
  // A valid load wins over a coincident tick and restarts the second;
  // a rejected load only raises load_err and leaves counting untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      tm          <= RST_TIME;
      sec_pulse_q <= 1'b0;
      load_err_q  <= 1'b0;
      alarm_hit_q <= 1'b0;
    end else begin
      sec_pulse_q <= 1'b0;
      load_err_q  <= 1'b0;
      alarm_hit_q <= 1'b0;
      if (bus.run_en) cnt <= tick ? '0 : cnt + 1'b1;
      if (bus.load_valid && load_ok) begin
        tm  <= bus.load_time;
        cnt <= '0;
      end else begin
        if (bus.load_valid) load_err_q <= 1'b1;
        if (tick) begin
          tm          <= nxt;
          sec_pulse_q <= 1'b1;
          alarm_hit_q <= bus.alarm_en && alarm_ok && (nxt == bus.alarm_time);
        end
      end
    end
  end

  assign bus.time_bcd  = tm;
  assign bus.sec_pulse = sec_pulse_q;
  assign bus.load_err  = load_err_q;
  assign bus.alarm_hit = alarm_hit_q;

  // Glyph code per digit, same ordering as time_bcd.
  for (genvar g = 0; g < 6; g++) begin : g_glyph
    assign bus.disp_time[g*GLYPH_W +: GLYPH_W] = GLYPH_W'(GLYPH_BASE) + GLYPH_W'(tm[g*4 +: 4]);
  end

endmodule
